mmio_bridge: RTL and testbench

- Sits directly downstream of the CPU top's memory port, between the CPU and the block RAM / UART.
- Decodes each CPU byte access into RAM, UART data (0x30000) or system-control (0x30004–0x30007) targets.
- Buffers outgoing UART bytes in a TX FIFO and drives the CPU's io_buffer_full back-pressure input.
- Returns all read data exactly one cycle after the request, which is the CPU's fixed load contract.

---
 rtl/mmio_pkg.sv | 25 ++
 rtl/mmio_bridge_if.sv | 23 ++
 rtl/mmio_tx_fifo.sv | 68 ++++++
 rtl/mmio_bridge.sv | 150 +++++++++++++++
 tb/tb_mmio_bridge.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// Shared constants and types for the CPU memory-mapped IO bridge.
//   IO_SEL    : mem_a[17:16] pattern selecting the IO window
//   UART_OFS  : UART data register offset (0x30000)
//   CNT_OFS   : cycle-counter snapshot base offset (0x30004..0x30007)
//   rd_sel_e  : registered read-mux select for the one-cycle load return
package mmio_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 32;

  localparam logic [1:0] IO_SEL   = 2'b11;
  localparam logic [2:0] UART_OFS = 3'h0;
  localparam logic [2:0] CNT_OFS  = 3'h4;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_IO,
    SEL_CNT0,
    SEL_CNT1,
    SEL_CNT2,
    SEL_CNT3
  } rd_sel_e;

endpackage

// File: rtl/mmio_bridge_if.sv
// CPU memory port as seen by the bridge.
//   mem_a / mem_dout / mem_wr : CPU byte request (master -> slave)
//   mem_din                   : load data, valid one cycle after the request
//   io_buffer_full            : TX back-pressure towards the CPU
interface mmio_bridge_if;
  import mmio_pkg::*;

  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_din;
  logic              io_buffer_full;

  modport master (
    output mem_a, mem_dout, mem_wr,
    input  mem_din, io_buffer_full
  );

  modport slave (
    input  mem_a, mem_dout, mem_wr,
    output mem_din, io_buffer_full
  );
endinterface

// File: rtl/mmio_tx_fifo.sv
// UART transmit FIFO with sticky overflow and registered near-full flag.
//   push/push_data : enqueue request (dropped when full unless a pop frees a slot)
//   tx_ready       : UART accepts the head this cycle
//   tx_data/valid  : head entry / non-empty
//   near_full      : registered (count_next >= DEPTH-MARGIN)
//   overflow       : sticky, set when a push is dropped
module mmio_tx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned MARGIN = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       near_full,
  output logic       overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic             pop_c;
  logic             full_c;
  logic             push_ok_c;
  logic [CNT_W-1:0] count_next_c;

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  always_comb begin
    pop_c        = (count_q != '0) && tx_ready;
    full_c       = (count_q == CNT_W'(DEPTH));
    push_ok_c    = push && (!full_c || pop_c);
    count_next_c = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
  end

  assign tx_valid = (count_q != '0);
  assign tx_data  = mem_q[rd_ptr_q];

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk_in) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      near_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (pop_c)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      count_q   <= count_next_c;
      near_full <= (count_next_c >= CNT_W'(DEPTH - MARGIN));
      if (push && !push_ok_c) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// Decodes CPU byte accesses into block RAM, UART and system-control targets.
//   clk_in, rst_in (async active-low), rdy_in (low = no side effects)
//   cpu            : CPU memory port (mem_a/mem_dout/mem_wr in, mem_din/io_buffer_full out)
//   ram_*          : synchronous block RAM port (1-cycle read latency)
//   rx_*           : UART receive head and consume pulse
//   tx_*           : UART transmit FIFO head / handshake
//   program_done   : sticky stop flag, tx_overflow : sticky dropped-push flag
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned FULL_MARGIN = 2,
  parameter int unsigned RAM_AW      = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  mmio_bridge_if.slave      cpu,
  output logic [RAM_AW-1:0] ram_a,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_pop,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              program_done,
  output logic              tx_overflow
);

  logic       is_io_c;
  logic       io_hit_c;
  logic       uart_c;
  logic       cnt_c;
  logic       cnt_base_c;
  logic       rd_c;
  logic       wr_act_c;
  logic [2:0] ofs_c;

  logic       push_c;
  logic [7:0] push_data_c;
  logic       snap_en_c;
  logic       done_set_c;
  rd_sel_e    sel_d;
  logic [7:0] io_byte_d;

  rd_sel_e          sel_q;
  logic [7:0]       io_byte_q;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] snap_q;
  logic             near_full;

  // Only mem_a[17:0] participates in decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu.mem_a[ADDR_W-1:18];

  // Target decode; IO registers live at 0x30000 and 0x30004..0x30007.
  always_comb begin
    ofs_c      = cpu.mem_a[2:0];
    is_io_c    = (cpu.mem_a[17:16] == IO_SEL);
    io_hit_c   = is_io_c && (cpu.mem_a[15:3] == 13'h0);
    uart_c     = io_hit_c && (ofs_c == UART_OFS);
    cnt_c      = io_hit_c && ((ofs_c & CNT_OFS) == CNT_OFS);
    cnt_base_c = cnt_c && (ofs_c == CNT_OFS);
    rd_c       = !cpu.mem_wr;
    wr_act_c   = cpu.mem_wr && rdy_in;
  end

  // RAM strobe is gated by reset so nothing is written while held in reset.
  assign ram_a     = cpu.mem_a[RAM_AW-1:0];
  assign ram_wdata = cpu.mem_dout;
  assign ram_we    = wr_act_c && !is_io_c && rst_in;
  assign rx_pop    = rd_c && rdy_in && uart_c && rx_valid && rst_in;

  // Side effects of IO accesses: TX pushes, stop flag, counter snapshot.
  always_comb begin
    push_c      = wr_act_c && ((uart_c && (cpu.mem_dout != 8'h00)) || cnt_base_c);
    push_data_c = uart_c ? cpu.mem_dout : 8'h00;
    done_set_c  = wr_act_c && cnt_base_c;
    snap_en_c   = rd_c && rdy_in && cnt_base_c;
  end

  // Next read-mux select and captured IO byte for the one-cycle load return.
  always_comb begin
    sel_d     = SEL_IO;
    io_byte_d = 8'h00;
    if (!is_io_c) begin
      sel_d = SEL_RAM;
    end else if (cnt_c) begin
      case (ofs_c[1:0])
        2'd0:    sel_d = SEL_CNT0;
        2'd1:    sel_d = SEL_CNT1;
        2'd2:    sel_d = SEL_CNT2;
        default: sel_d = SEL_CNT3;
      endcase
    end
    if (rd_c && uart_c && rx_valid) io_byte_d = rx_data;
  end

  // Reset parks the mux on the IO byte so mem_din reads zero.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sel_q        <= SEL_IO;
      io_byte_q    <= 8'h00;
      cyc_q        <= '0;
      snap_q       <= '0;
      program_done <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      io_byte_q <= io_byte_d;
      cyc_q     <= cyc_q + CNT_W'(1);
      if (snap_en_c)  snap_q       <= cyc_q;
      if (done_set_c) program_done <= 1'b1;
    end
  end

  // Load data mux; RAM data arrives from the RAM's own output register.
  always_comb begin
    cpu.mem_din = 8'h00;
    case (sel_q)
      SEL_RAM:  cpu.mem_din = ram_rdata;
      SEL_IO:   cpu.mem_din = io_byte_q;
      SEL_CNT0: cpu.mem_din = snap_q[7:0];
      SEL_CNT1: cpu.mem_din = snap_q[15:8];
      SEL_CNT2: cpu.mem_din = snap_q[23:16];
      SEL_CNT3: cpu.mem_din = snap_q[31:24];
      default:  cpu.mem_din = 8'h00;
    endcase
  end

  assign cpu.io_buffer_full = near_full;

  mmio_tx_fifo #(
    .DEPTH  (TX_DEPTH),
    .MARGIN (FULL_MARGIN)
  ) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (push_c),
    .push_data (push_data_c),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .near_full (near_full),
    .overflow  (tx_overflow)
  );

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed scenarios followed by a
// randomized phase, all checked against a queue/array reference model.
module tb_mmio_bridge;

  localparam int unsigned TX_DEPTH    = 16;
  localparam int unsigned FULL_MARGIN = 2;
  localparam int unsigned RAM_AW      = 17;
  localparam logic [31:0] IDLE_A      = 32'h0003_0008;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b0;
  logic              rdy_in = 1'b1;
  logic [RAM_AW-1:0] ram_a;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_pop;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic              program_done;
  logic              tx_overflow;

  mmio_bridge_if bus ();

  mmio_bridge #(
    .TX_DEPTH    (TX_DEPTH),
    .FULL_MARGIN (FULL_MARGIN),
    .RAM_AW      (RAM_AW)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .cpu          (bus),
    .ram_a        (ram_a),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_pop       (rx_pop),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .program_done (program_done),
    .tx_overflow  (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  // Block RAM environment: synchronous read-before-write.
  bit [7:0] ram_mem [0:(1<<RAM_AW)-1];
  always @(posedge clk_in) begin
    if (ram_we) ram_mem[ram_a] <= ram_wdata;
    ram_rdata <= ram_mem[ram_a];
  end

  // Reference: free-running cycle count since reset release.
  int unsigned cyc;
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // Reference model state.
  bit [7:0]    mram [0:(1<<RAM_AW)-1];
  logic [7:0]  q[$];
  logic [7:0]  rxq[$];
  bit          m_full, m_done, m_ovf;
  logic [31:0] m_snap;
  bit          exp_rd_valid;
  logic [7:0]  exp_din;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    rxq.delete();
    m_full = 0; m_done = 0; m_ovf = 0;
    m_snap = 32'h0;
    exp_rd_valid = 0;
  endtask

  // One bus cycle, entered and left just after a falling edge.
  task automatic cycle(input logic [31:0] a, input logic [7:0] d, input logic wr,
                       input logic rdy, input logic txr);
    bit io, uart, cnt, exp_we, exp_pop, pu, po;
    logic [7:0] pd;
    int ofs;
    check("tx_valid", tx_valid, q.size() != 0);
    if (q.size() != 0) check("tx_data", tx_data, q[0]);
    check("io_buffer_full", bus.io_buffer_full, m_full);
    check("program_done", program_done, m_done);
    check("tx_overflow", tx_overflow, m_ovf);
    if (exp_rd_valid) check("mem_din", bus.mem_din, exp_din);

    bus.mem_a = a; bus.mem_dout = d; bus.mem_wr = wr;
    rdy_in = rdy; tx_ready = txr;
    rx_valid = (rxq.size() != 0);
    rx_data  = rx_valid ? rxq[0] : 8'($urandom());
    #1;
    io   = (a[17:16] == 2'b11);
    uart = io && (a[15:0] == 16'h0);
    cnt  = io && (a[15:2] == 14'h1);
    ofs  = int'(a[1:0]);
    exp_we = wr && rdy && !io;
    check("ram_we", ram_we, exp_we);
    check("ram_a", ram_a, a[RAM_AW-1:0]);
    if (exp_we) check("ram_wdata", ram_wdata, d);
    exp_pop = !wr && rdy && uart && (rxq.size() != 0);
    check("rx_pop", rx_pop, exp_pop);

    exp_rd_valid = !wr;
    exp_din = 8'h00;
    if (!wr) begin
      if (!io) exp_din = mram[a[RAM_AW-1:0]];
      else if (uart) exp_din = (rxq.size() != 0) ? rxq[0] : 8'h00;
      else if (cnt) begin
        if (ofs == 0 && rdy) m_snap = cyc;
        exp_din = m_snap[8*ofs +: 8];
      end
    end
    if (exp_we) mram[a[RAM_AW-1:0]] = d;
    pu = wr && rdy && ((uart && d != 8'h00) || (cnt && ofs == 0));
    pd = uart ? d : 8'h00;
    if (wr && rdy && cnt && ofs == 0) m_done = 1;
    po = (q.size() != 0) && txr;
    if (po) void'(q.pop_front());
    if (pu) begin
      if (q.size() < TX_DEPTH) q.push_back(pd);
      else m_ovf = 1;
    end
    m_full = (q.size() >= TX_DEPTH - FULL_MARGIN);
    if (exp_pop) void'(rxq.pop_front());
    @(negedge clk_in);
  endtask

  task automatic idle(input logic txr);
    cycle(IDLE_A, 8'h00, 1'b0, 1'b1, txr);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset();
    #2 rst_in = 1'b0;
    #1;
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_io_buffer_full", bus.io_buffer_full, 1'b0);
    check("rst_program_done", program_done, 1'b0);
    check("rst_tx_overflow", tx_overflow, 1'b0);
    check("rst_mem_din", bus.mem_din, 8'h00);
    bus.mem_a = 32'h0000_0100; bus.mem_wr = 1'b1; rdy_in = 1'b1;
    #1 check("rst_ram_we", ram_we, 1'b0);
    bus.mem_a = 32'h0003_0000; bus.mem_wr = 1'b0; rx_valid = 1'b1;
    #1 check("rst_rx_pop", rx_pop, 1'b0);
    @(negedge clk_in);
    rst_in = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] a;
    logic [7:0]  d;
    bus.mem_a = IDLE_A; bus.mem_dout = 8'h00; bus.mem_wr = 1'b0;
    model_reset();
    @(negedge clk_in);
    do_reset();

    // RAM round trip
    cycle(32'h0000_1234, 8'hA5, 1'b1, 1'b1, 1'b0);
    cycle(32'h0000_1234, 8'h00, 1'b0, 1'b1, 1'b0);
    check("ram_roundtrip", bus.mem_din, 8'hA5);
    idle(1'b0);

    // UART TX with a dropped zero byte
    cycle(32'h0003_0000, 8'h41, 1'b1, 1'b1, 1'b0);
    cycle(32'h0003_0000, 8'h00, 1'b1, 1'b1, 1'b0);
    cycle(32'h0003_0000, 8'h42, 1'b1, 1'b1, 1'b0);
    check("tx_head_41", tx_data, 8'h41);
    idle(1'b1);
    check("tx_head_42", tx_data, 8'h42);
    idle(1'b1);
    idle(1'b1);
    check("tx_empty_after_drain", tx_valid, 1'b0);

    // Back-pressure and overflow
    for (int i = 0; i < 13; i++) cycle(32'h0003_0000, 8'(8'h61 + i), 1'b1, 1'b1, 1'b0);
    check("near_full_at_13", bus.io_buffer_full, 1'b0);
    cycle(32'h0003_0000, 8'h70, 1'b1, 1'b1, 1'b0);
    check("near_full_at_14", bus.io_buffer_full, 1'b1);
    for (int i = 0; i < 3; i++) cycle(32'h0003_0000, 8'(8'h71 + i), 1'b1, 1'b1, 1'b0);
    check("overflow_set", tx_overflow, 1'b1);
    // Push while full with a simultaneous pop is accepted.
    cycle(32'h0003_0000, 8'h7E, 1'b1, 1'b1, 1'b1);
    check("overflow_sticky", tx_overflow, 1'b1);
    n = 0;
    while (tx_valid && n < 40) begin idle(1'b1); n++; end
    check("drain_count", n, 16);

    // Counter coherence
    do_reset();
    repeat (256) idle(1'b0);
    cycle(32'h0003_0004, 8'h00, 1'b0, 1'b1, 1'b0);
    check("cnt_b0", bus.mem_din, 8'h00);
    cycle(32'h0003_0005, 8'h00, 1'b0, 1'b1, 1'b0);
    check("cnt_b1", bus.mem_din, 8'h01);
    cycle(32'h0003_0006, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(32'h0003_0007, 8'h00, 1'b0, 1'b1, 1'b0);
    repeat (10) idle(1'b0);
    cycle(32'h0003_0005, 8'h00, 1'b0, 1'b1, 1'b0);
    check("cnt_b1_stable", bus.mem_din, 8'h01);

    // RX read and stop
    rxq.push_back(8'h37);
    cycle(32'h0003_0000, 8'h00, 1'b0, 1'b1, 1'b0);
    check("rx_byte", bus.mem_din, 8'h37);
    cycle(32'h0003_0000, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(32'h0003_0004, 8'h55, 1'b1, 1'b1, 1'b0);
    check("stop_done", program_done, 1'b1);
    check("stop_byte", tx_data, 8'h00);
    idle(1'b1);

    // Reset mid-drain, then rdy_in gating
    for (int i = 0; i < 5; i++) cycle(32'h0003_0000, 8'(8'h21 + i), 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    do_reset();
    cycle(32'h0003_0000, 8'h55, 1'b1, 1'b0, 1'b0);
    cycle(32'h0000_0200, 8'h66, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    check("rdy_low_no_push", tx_valid, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 5))
        0, 1: a = {14'($urandom()), 1'b0, 1'($urandom()), 10'h0, 6'($urandom())};
        2:    a = 32'h0003_0000;
        3:    a = 32'h0003_0004 + 32'($urandom_range(0, 3));
        4:    a = 32'h0003_0000 | 32'($urandom_range(0, 31));
        default: a = {14'($urandom()), 2'b11, 16'($urandom_range(0, 15))};
      endcase
      d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
      if (rxq.size() < 2 && $urandom_range(0, 3) == 0) rxq.push_back(8'($urandom()));
      cycle(a, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 2) == 0));
    end
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
